// File: rtl/router_pkt_reg.sv
// Router packet register stage: header/payload/parity framing, per-channel
// FIFO write steering, running check value and a skid buffer for FIFO stalls.
module router_pkt_reg #(
  parameter int DW          = 8,
  parameter int NCH         = 3,
  parameter int PARITY_MODE = 0,
  parameter int SKID_DEPTH  = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           packet_valid,
  input  logic [DW-1:0]  datain,
  input  logic [NCH-1:0] fifo_full,
  input  logic [NCH-1:0] fifo_empty,
  output logic [NCH-1:0] write_enb,
  output logic [DW-1:0]  dout,
  output logic           busy,
  output logic           parity_done,
  output logic           low_packet_valid,
  output logic           err,
  output logic           drop,
  output logic [15:0]    err_count
);

  localparam int AW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EMPTY,
    LOAD_DATA,
    DRAIN,
    CHECK,
    DROP
  } state_t;

  state_t state;
  state_t state_n;

  logic [AW-1:0]  ch;
  logic [AW-1:0]  addr;
  logic [AW-1:0]  ch_sel;
  logic [NCH-1:0] oh_sel;
  logic [DW-1:0]  hdr;
  logic [DW-1:0]  chk;
  logic [DW-1:0]  rx_par;
  logic           ovf;

  logic [DW-1:0]  skid [SKID_DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_n;

  logic addr_ok;
  logic full_sel;
  logic acc;
  logic hdr_acc;
  logic beat_wr;
  logic direct;
  logic push;
  logic pop;
  logic lost;
  logic busy_n;
  logic hdr_go;

  function automatic logic [DW-1:0] fold(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    if (PARITY_MODE == 1) return a + b;
    return a ^ b;
  endfunction

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    if (p == PW'(SKID_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    addr     = datain[AW-1:0];
    addr_ok  = int'(addr) < NCH;
    ch_sel   = (state == IDLE) ? addr : ch;
    oh_sel   = {{(NCH-1){1'b0}}, 1'b1} << ch_sel;
    full_sel = fifo_full[ch_sel];
    acc      = !busy &&
               ((state == IDLE && packet_valid) || state == LOAD_DATA);
    hdr_acc  = acc && state == IDLE;
    // Headers bound for a busy FIFO are parked in hdr, not written yet.
    beat_wr  = acc && (state == LOAD_DATA ||
                       (addr_ok && fifo_empty[ch_sel]));
    hdr_go   = state == WAIT_EMPTY && fifo_empty[ch];
    pop      = cnt != '0 && !full_sel;
    direct   = beat_wr && cnt == '0 && !full_sel;
    push     = beat_wr && !direct &&
               (cnt < CW'(SKID_DEPTH) || pop);
    lost     = beat_wr && !direct && !push;
    cnt_n    = cnt + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (hdr_acc) begin
          if (!addr_ok)                state_n = DROP;
          else if (fifo_empty[ch_sel]) state_n = LOAD_DATA;
          else                         state_n = WAIT_EMPTY;
        end
      end
      WAIT_EMPTY: if (hdr_go) state_n = LOAD_DATA;
      LOAD_DATA:  if (acc && !packet_valid) state_n = DRAIN;
      DRAIN:      if (cnt == '0) state_n = CHECK;
      CHECK:      state_n = IDLE;
      DROP:       if (!busy && !packet_valid) state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  // DROP keeps busy low so the rest of a bad packet can be sunk.
  always_comb begin
    busy_n = hdr_acc || cnt_n != '0 ||
             !(state_n inside {IDLE, LOAD_DATA, DROP}) ||
             (state_n == LOAD_DATA && full_sel);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      ch               <= '0;
      hdr              <= '0;
      chk              <= '0;
      rx_par           <= '0;
      ovf              <= 1'b0;
      head             <= '0;
      tail             <= '0;
      cnt              <= '0;
      write_enb        <= '0;
      dout             <= '0;
      busy             <= 1'b0;
      parity_done      <= 1'b0;
      low_packet_valid <= 1'b0;
      err              <= 1'b0;
      drop             <= 1'b0;
      err_count        <= '0;
    end else begin
      state            <= state_n;
      busy             <= busy_n;
      cnt              <= cnt_n;
      write_enb        <= '0;
      parity_done      <= 1'b0;
      low_packet_valid <= 1'b0;
      err              <= 1'b0;
      drop             <= 1'b0;

      if (hdr_acc) begin
        ch  <= addr;
        hdr <= datain;
        chk <= datain;
      end

      if (acc && state == LOAD_DATA) begin
        if (packet_valid) begin
          chk <= fold(chk, datain);
        end else begin
          rx_par           <= datain;
          low_packet_valid <= 1'b1;
        end
      end

      if (direct) begin
        write_enb <= oh_sel;
        dout      <= datain;
      end else if (pop) begin
        write_enb <= oh_sel;
        dout      <= skid[head];
        head      <= inc(head);
      end

      if (push) begin
        skid[tail] <= datain;
        tail       <= inc(tail);
      end

      if (hdr_go) begin
        write_enb <= oh_sel;
        dout      <= hdr;
      end

      if (state == IDLE) ovf <= 1'b0;
      if (lost)          ovf <= 1'b1;

      if (state == DRAIN && state_n == CHECK) begin
        parity_done <= 1'b1;
        if (chk != rx_par || ovf) begin
          err <= 1'b1;
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
      end

      if (state == DROP && state_n == IDLE) drop <= 1'b1;
    end
  end

endmodule
